// File: rtl/ucsbece154a_dmem_pkg.sv
// ----------------------------------------------------------------------------
// ucsbece154a_dmem_pkg
// Shared definitions for the data-memory arbiter and its picker:
//   - arbiter state encoding (IDLE, LOCK0, LOCK1)
//   - default memory depth and lock length
//   - requester port indices
//   - word-alignment helper
// Optional build macro used by the users of this package: DMEM_ARB_RR_EN.
// ----------------------------------------------------------------------------
package ucsbece154a_dmem_pkg;

  localparam int NUM_WORDS_DEF = 64;
  localparam int LOCK_MAX_DEF  = 15;

  // Port indices; also the encoding stored in last_grant.
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } arb_state_t;

  // True when the byte offset selects the first byte of a word.
  function automatic logic is_word_aligned(input logic [1:0] byte_off);
    return (byte_off == 2'b00);
  endfunction

endpackage

// File: rtl/ucsbece154a_rr_pick.sv
// ----------------------------------------------------------------------------
// ucsbece154a_rr_pick
// Two-way picker used by the arbiter in its unlocked state.
//   i_req[1:0]    request vector, bit n = port n
//   i_last_grant  port that received the most recent grant
//   o_gnt[1:0]    one-hot grant (all zero when nothing requests)
// Build option DMEM_ARB_RR_EN:
//   defined   - a tie goes to the port that did not win last (round-robin)
//   undefined - a tie always goes to port 0; i_last_grant is ignored
// ----------------------------------------------------------------------------
module ucsbece154a_rr_pick
  import ucsbece154a_dmem_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic [1:0] o_gnt
);

`ifndef DMEM_ARB_RR_EN
  // Fixed priority never consults history.
  logic w_unused_last_grant;
  assign w_unused_last_grant = i_last_grant;
`endif

  // Grant selection: single requests win outright, ties resolved by build option.
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
`ifdef DMEM_ARB_RR_EN
      2'b11:   o_gnt = (i_last_grant == PORT0) ? 2'b10 : 2'b01;
`else
      2'b11:   o_gnt = 2'b01;
`endif
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ucsbece154a_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// ucsbece154a_dmem_arbiter
// Shares a single-port NUM_WORDS-word data memory between port 0 (core LSU)
// and port 1 (debug/DMA loader). One grant per cycle, combinational grant,
// registered one-cycle response. A requester may hold a lock to keep the
// memory across consecutive grants (read-modify-write); the lock is forcibly
// dropped after LOCK_MAX consecutive locked grants.
//
// Ports:
//   clk, rst_n_i              clock, synchronous active-low reset
//   reqN_i/weN_i/aN_i/wdN_i   request, write strobe, byte address, write data
//   lockN_i                   keep the grant after this access
//   gntN_o                    access accepted this cycle (combinational)
//   rvalidN_o                 response for port N, one cycle after its grant
//   rdata_o, err_o            registered read data / misalignment flag
//   mem_we_o/mem_a_o/mem_wd_o drive the memory; mem_rd_i is its async read
//
// Build option DMEM_ARB_RR_EN: round-robin instead of port-0 priority on
// unlocked ties (see ucsbece154a_rr_pick). Lock behaviour is the same.
// ----------------------------------------------------------------------------
module ucsbece154a_dmem_arbiter
  import ucsbece154a_dmem_pkg::*;
#(
  parameter int NUM_WORDS  = NUM_WORDS_DEF,
  parameter int ADDR_WIDTH = $clog2(NUM_WORDS),
  parameter int LOCK_MAX   = LOCK_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst_n_i,
  input  logic        req0_i,
  input  logic        we0_i,
  input  logic [31:0] a0_i,
  input  logic [31:0] wd0_i,
  input  logic        lock0_i,
  output logic        gnt0_o,
  input  logic        req1_i,
  input  logic        we1_i,
  input  logic [31:0] a1_i,
  input  logic [31:0] wd1_i,
  input  logic        lock1_i,
  output logic        gnt1_o,
  output logic        rvalid0_o,
  output logic        rvalid1_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        mem_we_o,
  output logic [31:0] mem_a_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i
);

  localparam int LOCK_CW = $clog2(LOCK_MAX + 1);
  localparam logic [LOCK_CW-1:0] LOCK_MAX_C = LOCK_CW'(LOCK_MAX);
  localparam logic [LOCK_CW-1:0] CNT_ONE    = LOCK_CW'(1'b1);
  localparam logic [LOCK_CW-1:0] CNT_ZERO   = {LOCK_CW{1'b0}};

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic               r_last_grant;
  logic               w_last_grant_nxt;
  logic [LOCK_CW-1:0] r_lock_cnt;
  logic [LOCK_CW-1:0] w_lock_cnt_nxt;
  logic [LOCK_CW-1:0] w_cnt_inc;

  // After a forced release the port that held the lock loses the next tie,
  // otherwise fixed priority would let port 0 re-lock immediately and
  // LOCK_MAX would not bound the other port's wait.
  logic               r_yield_valid;
  logic               w_yield_valid_nxt;
  logic               r_yield_port;
  logic               w_yield_port_nxt;

  logic [1:0]         w_pick_gnt;
  logic [1:0]         w_gnt;
  logic               w_any_gnt;
  logic               w_sel1;
  logic [31:0]        w_a_sel;
  logic               w_we_sel;
  logic               w_lock_sel;
  logic               w_aligned;

  logic               r_rvalid0;
  logic               r_rvalid1;
  logic [31:0]        r_rdata;
  logic               r_err;

  ucsbece154a_rr_pick u_pick (
    .i_req        ({req1_i, req0_i}),
    .i_last_grant (r_last_grant),
    .o_gnt        (w_pick_gnt)
  );

  // Grant decision: nothing in reset, picker (or yield) when idle, owner only when locked.
  always_comb begin
    w_gnt = 2'b00;
    if (!rst_n_i) begin
      w_gnt = 2'b00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_yield_valid && req0_i && req1_i) begin
            w_gnt = (r_yield_port == PORT0) ? 2'b10 : 2'b01;
          end else begin
            w_gnt = w_pick_gnt;
          end
        end
        ST_LOCK0: w_gnt = {1'b0, req0_i};
        ST_LOCK1: w_gnt = {req1_i, 1'b0};
        default:  w_gnt = 2'b00;
      endcase
    end
  end

  assign w_any_gnt  = |w_gnt;
  assign w_sel1     = w_gnt[1];
  assign w_a_sel    = w_sel1 ? a1_i    : a0_i;
  assign w_we_sel   = w_sel1 ? we1_i   : we0_i;
  assign w_lock_sel = w_sel1 ? lock1_i : lock0_i;
  assign w_aligned  = is_word_aligned(w_a_sel[1:0]);

  // Locked-grant count this grant would reach; a grant from IDLE is the first.
  assign w_cnt_inc  = (r_state == ST_IDLE) ? CNT_ONE : (r_lock_cnt + CNT_ONE);

  assign gnt0_o    = w_gnt[0];
  assign gnt1_o    = w_gnt[1];
  assign mem_we_o  = w_any_gnt & w_we_sel & w_aligned;
  // Same bits as the selected address; the middle field is the word index
  // the attached memory decodes.
  assign mem_a_o   = {w_a_sel[31:ADDR_WIDTH+2], w_a_sel[ADDR_WIDTH+1:2], w_a_sel[1:0]};
  assign mem_wd_o  = w_sel1 ? wd1_i : wd0_i;

  // Next state, lock counter, yield marker and last_grant from this cycle's grant.
  always_comb begin
    w_state_nxt       = r_state;
    w_lock_cnt_nxt    = r_lock_cnt;
    w_yield_valid_nxt = r_yield_valid;
    w_yield_port_nxt  = r_yield_port;
    w_last_grant_nxt  = r_last_grant;
    if (w_any_gnt) begin
      w_last_grant_nxt  = w_sel1;
      w_yield_valid_nxt = 1'b0;
      if (w_lock_sel && (w_cnt_inc < LOCK_MAX_C)) begin
        w_state_nxt    = w_sel1 ? ST_LOCK1 : ST_LOCK0;
        w_lock_cnt_nxt = w_cnt_inc;
      end else begin
        w_state_nxt    = ST_IDLE;
        w_lock_cnt_nxt = CNT_ZERO;
        if (w_lock_sel) begin
          // Lock still requested but LOCK_MAX reached: forced release.
          w_yield_valid_nxt = 1'b1;
          w_yield_port_nxt  = w_sel1;
        end else begin
          w_yield_valid_nxt = 1'b0;
        end
      end
    end else begin
      if ((r_state == ST_LOCK0) || (r_state == ST_LOCK1)) begin
        w_state_nxt = r_state;
      end else begin
        w_state_nxt    = ST_IDLE;
        w_lock_cnt_nxt = CNT_ZERO;
      end
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      r_state       <= ST_IDLE;
      r_last_grant  <= PORT1;
      r_lock_cnt    <= CNT_ZERO;
      r_yield_valid <= 1'b0;
      r_yield_port  <= PORT0;
    end else begin
      r_state       <= w_state_nxt;
      r_last_grant  <= w_last_grant_nxt;
      r_lock_cnt    <= w_lock_cnt_nxt;
      r_yield_valid <= w_yield_valid_nxt;
      r_yield_port  <= w_yield_port_nxt;
    end
  end

  // Response registers: strobe, read data (0 for writes) and misalignment flag.
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata   <= 32'h0000_0000;
      r_err     <= 1'b0;
    end else begin
      r_rvalid0 <= w_gnt[0];
      r_rvalid1 <= w_gnt[1];
      if (w_any_gnt && !w_we_sel) begin
        r_rdata <= mem_rd_i;
      end else begin
        r_rdata <= 32'h0000_0000;
      end
      r_err     <= w_any_gnt & ~w_aligned;
    end
  end

  assign rvalid0_o = r_rvalid0;
  assign rvalid1_o = r_rvalid1;
  assign rdata_o   = r_rdata;
  assign err_o     = r_err;

endmodule

// File: tb/tb_ucsbece154a_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ucsbece154a_dmem_arbiter
// Directed bench for ucsbece154a_dmem_arbiter with a behavioural 64-word
// memory attached. Expected values are written out by hand; tie-break
// expectations follow DMEM_ARB_RR_EN.
// ----------------------------------------------------------------------------
module tb_ucsbece154a_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, we0, lock0, req1, we1, lock1;
  logic [31:0] a0, wd0, a1, wd1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err, mem_we;
  logic [31:0] rdata, mem_a, mem_wd, mem_rd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Attached memory: write on posedge, combinational read, word index a[7:2].
  logic [31:0] mem [0:63];
  logic        unused_addr_bits;
  assign unused_addr_bits = ^{mem_a[31:8], mem_a[1:0]};
  assign mem_rd = mem[mem_a[7:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_a[7:2]] <= mem_wd;
  end

  ucsbece154a_dmem_arbiter dut (
    .clk(clk), .rst_n_i(rst_n),
    .req0_i(req0), .we0_i(we0), .a0_i(a0), .wd0_i(wd0), .lock0_i(lock0), .gnt0_o(gnt0),
    .req1_i(req1), .we1_i(we1), .a1_i(a1), .wd1_i(wd1), .lock1_i(lock1), .gnt1_o(gnt1),
    .rvalid0_o(rvalid0), .rvalid1_o(rvalid1), .rdata_o(rdata), .err_o(err),
    .mem_we_o(mem_we), .mem_a_o(mem_a), .mem_wd_o(mem_wd), .mem_rd_i(mem_rd)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drv0(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic l);
    req0 = r; we0 = w; a0 = a; wd0 = d; lock0 = l;
  endtask

  task automatic drv1(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic l);
    req1 = r; we1 = w; a1 = a; wd1 = d; lock1 = l;
  endtask

  // Combinational checks at negedge of the current cycle.
  task automatic chk_gnt(input string tag, input logic e0, input logic e1);
    @(negedge clk);
    chk_eq({tag, "_gnt0"}, 32'(gnt0), 32'(e0));
    chk_eq({tag, "_gnt1"}, 32'(gnt1), 32'(e1));
  endtask

  // Registered response checks just after the closing posedge.
  task automatic chk_rsp(input string tag, input logic v0, input logic v1,
                         input logic [31:0] d, input logic e);
    @(posedge clk); #1;
    chk_eq({tag, "_rvalid0"}, 32'(rvalid0), 32'(v0));
    chk_eq({tag, "_rvalid1"}, 32'(rvalid1), 32'(v1));
    chk_eq({tag, "_rdata"},   rdata, d);
    chk_eq({tag, "_err"},     32'(err), 32'(e));
  endtask

  initial begin
    logic eg0;
    // ---------------- reset with a write pending ----------------
    rst_n = 1'b0;
    drv0(1'b1, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 1'b0);
    drv1(1'b1, 1'b0, 32'h0000_0014, 32'h0000_0000, 1'b0);
    chk_gnt("rst", 1'b0, 1'b0);
    chk_eq("rst_mem_we", 32'(mem_we), 32'h0);
    @(posedge clk); #1;
    chk_rsp("rst", 1'b0, 1'b0, 32'h0, 1'b0);

    // ---------------- write then read 0x10 ----------------
    rst_n = 1'b1;
    drv1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drv0(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    chk_gnt("wr10", 1'b1, 1'b0);
    chk_eq("wr10_mem_we", 32'(mem_we), 32'h1);
    chk_eq("wr10_mem_a", mem_a, 32'h0000_0010);
    chk_rsp("wr10", 1'b1, 1'b0, 32'h0, 1'b0);
    drv0(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    chk_gnt("rd10", 1'b1, 1'b0);
    chk_eq("rd10_mem_we", 32'(mem_we), 32'h0);
    chk_rsp("rd10", 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);

    // port 1 writes 0x14 so its last grant precedes the tie test
    drv0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drv1(1'b1, 1'b1, 32'h0000_0014, 32'hCAFE_F00D, 1'b0);
    chk_gnt("wr14", 1'b0, 1'b1);
    chk_eq("wr14_mem_a", mem_a, 32'h0000_0014);
    chk_rsp("wr14", 1'b0, 1'b1, 32'h0, 1'b0);

    // ---------------- both read every cycle ----------------
    drv0(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    drv1(1'b1, 1'b0, 32'h0000_0014, 32'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      eg0 = RR ? ((k % 2) == 0) : 1'b1;
      chk_gnt("tie", eg0, ~eg0);
      chk_rsp("tie", eg0, ~eg0, eg0 ? 32'hDEAD_BEEF : 32'hCAFE_F00D, 1'b0);
    end

    // ---------------- port 1 lock for 3 grants, then unlocked ----------------
    drv0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drv1(1'b1, 1'b0, 32'h0000_0014, 32'h0, 1'b1);
    chk_gnt("lk1_a", 1'b0, 1'b1);
    chk_rsp("lk1_a", 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
    drv0(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk_gnt("lk1_b", 1'b0, 1'b1);
      @(posedge clk); #1;
    end
    lock1 = 1'b0;
    chk_gnt("lk1_c", 1'b0, 1'b1);
    chk_rsp("lk1_c", 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
    drv1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk_gnt("lk1_d", 1'b1, 1'b0);
    chk_rsp("lk1_d", 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);

    // ---------------- locked owner idle: no grant, other port waits ----------------
    drv0(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b1);
    chk_gnt("hold_a", 1'b1, 1'b0);
    @(posedge clk); #1;
    drv0(1'b0, 1'b0, 32'h0000_0018, 32'h0, 1'b1);
    drv1(1'b1, 1'b0, 32'h0000_0014, 32'h0, 1'b0);
    chk_gnt("hold_b", 1'b0, 1'b0);
    chk_eq("hold_b_mem_a", mem_a, 32'h0000_0018);
    chk_rsp("hold_b", 1'b0, 1'b0, 32'h0, 1'b0);
    drv0(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    chk_gnt("hold_c", 1'b1, 1'b0);
    @(posedge clk); #1;

    // ---------------- LOCK_MAX forced release ----------------
    drv1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drv0(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      if (k == 2)  drv1(1'b1, 1'b0, 32'h0000_0014, 32'h0, 1'b0);
      if (k == 17) drv1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      chk_gnt($sformatf("lkmax_%0d", k), (k != 16), (k == 16));
      if (k == 16) chk_rsp("lkmax_16", 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
      else begin @(posedge clk); #1; end
    end
    lock0 = 1'b0;
    chk_gnt("lkmax_rel", 1'b1, 1'b0);
    @(posedge clk); #1;

    // ---------------- misaligned write / read ----------------
    drv0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drv1(1'b1, 1'b1, 32'h0000_0020, 32'h0BAD_F00D, 1'b0);
    chk_gnt("wr20", 1'b0, 1'b1);
    chk_rsp("wr20", 1'b0, 1'b1, 32'h0, 1'b0);
    drv1(1'b1, 1'b1, 32'h0000_0022, 32'h1234_5678, 1'b0);
    chk_gnt("mis_wr", 1'b0, 1'b1);
    chk_eq("mis_wr_mem_we", 32'(mem_we), 32'h0);
    chk_rsp("mis_wr", 1'b0, 1'b1, 32'h0, 1'b1);
    drv1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drv0(1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b0);
    chk_gnt("rd20", 1'b1, 1'b0);
    chk_rsp("rd20", 1'b1, 1'b0, 32'h0BAD_F00D, 1'b0);
    drv0(1'b1, 1'b0, 32'h0000_0023, 32'h0, 1'b0);
    chk_gnt("mis_rd", 1'b1, 1'b0);
    chk_rsp("mis_rd", 1'b1, 1'b0, 32'h0BAD_F00D, 1'b1);

    // ---------------- reset while in LOCK0 ----------------
    drv0(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b1);
    chk_gnt("rlk_a", 1'b1, 1'b0);
    chk_rsp("rlk_a", 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
    rst_n = 1'b0;
    drv0(1'b1, 1'b1, 32'h0000_0010, 32'h1111_1111, 1'b1);
    chk_gnt("rlk_b", 1'b0, 1'b0);
    chk_eq("rlk_b_mem_we", 32'(mem_we), 32'h0);
    chk_rsp("rlk_b", 1'b0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    drv0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drv1(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    chk_gnt("rlk_c", 1'b0, 1'b1);
    chk_rsp("rlk_c", 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
